instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 16 +
 rtl/instr_mem_loader.sv | 99 +++++++++
 tb/tb_instr_mem_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared processor definitions used by the instruction memory loader:
// default memory geometry and the loader state encoding.
package instr_mem_loader_pkg;

   localparam int DEFAULT_ADDR_W = 16;
   localparam int DEFAULT_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GET_HI = 3'd1,
      ST_GET_LO = 3'd2,
      ST_WRITE  = 3'd3,
      ST_DONE   = 3'd4
   } loader_state_t;

endpackage

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles a big-endian byte stream into
// 16-bit instruction words and writes them to consecutive addresses
// through the instruction memory write port.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for Start after reset; byte stream ignored
// ST_GET_HI | ByteReady=1, waiting for the high byte of the next word
// ST_GET_LO | ByteReady=1, waiting for the low byte of the next word
// ST_WRITE  | WrEn=1 for one cycle; advance address, count down words
// ST_DONE   | load finished, Done held; Start begins a new load
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start,
   input  logic [ADDR_W-1:0] BaseAddr,
   input  logic [ADDR_W-1:0] WordCount,
   input  logic [7:0]        ByteIn,
   input  logic              ByteValid,
   output logic              ByteReady,
   output logic              WrEn,
   output logic [ADDR_W-1:0] WrAddr,
   output logic [DATA_W-1:0] WrData,
   output logic              Busy,
   output logic              Done
);

   loader_state_t     state;
   logic [ADDR_W-1:0] rem_cnt;

   // WrAddr is the address counter itself. The remaining counter starts at
   // WordCount; a count of 0 wraps to all ones on the first decrement, which
   // gives the full 2^ADDR_W words before it reaches 1.
   // FSM, counters and word assembly; all outputs are registered.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state     <= ST_IDLE;
         rem_cnt   <= '0;
         WrAddr    <= '0;
         WrData    <= '0;
         ByteReady <= 1'b0;
         WrEn      <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (Start) begin
                  WrAddr    <= BaseAddr;
                  rem_cnt   <= WordCount;
                  Done      <= 1'b0;
                  Busy      <= 1'b1;
                  ByteReady <= 1'b1;
                  state     <= ST_GET_HI;
               end
            end
            ST_GET_HI: begin
               if (ByteReady && ByteValid) begin
                  WrData[DATA_W-1 -: 8] <= ByteIn;
                  state                 <= ST_GET_LO;
               end
            end
            ST_GET_LO: begin
               if (ByteReady && ByteValid) begin
                  WrData[7:0] <= ByteIn;
                  ByteReady   <= 1'b0;
                  WrEn        <= 1'b1;
                  state       <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               WrEn    <= 1'b0;
               WrAddr  <= WrAddr + ADDR_W'(1);
               rem_cnt <= rem_cnt - ADDR_W'(1);
               if (rem_cnt == ADDR_W'(1)) begin
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  ByteReady <= 1'b1;
                  state     <= ST_GET_HI;
               end
            end
            default: begin
               ByteReady <= 1'b0;
               WrEn      <= 1'b0;
               Busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a 16-bit address instance for
// the main scenarios and a 4-bit address instance for the full-range load.
module tb_instr_mem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start4;
   logic [15:0] base_addr, word_count;
   logic [3:0]  base_addr4, word_count4;
   logic [7:0]  byte_in;
   logic        byte_valid;

   logic        byte_ready, wr_en, busy, done;
   logic [15:0] wr_addr, wr_data;
   logic        byte_ready4, wr_en4, busy4, done4;
   logic [3:0]  wr_addr4;
   logic [15:0] wr_data4;

   int errors = 0;
   int checks = 0;

   logic [31:0] q16[$];
   logic [31:0] q4[$];
   logic [15:0] wq[$];

   always #5 clk = ~clk;

   instr_mem_loader dut (
      .Clk(clk), .Rst_n(rst_n), .Start(start), .BaseAddr(base_addr),
      .WordCount(word_count), .ByteIn(byte_in), .ByteValid(byte_valid),
      .ByteReady(byte_ready), .WrEn(wr_en), .WrAddr(wr_addr),
      .WrData(wr_data), .Busy(busy), .Done(done)
   );

   instr_mem_loader #(.ADDR_W(4), .DATA_W(16)) dut4 (
      .Clk(clk), .Rst_n(rst_n), .Start(start4), .BaseAddr(base_addr4),
      .WordCount(word_count4), .ByteIn(byte_in), .ByteValid(byte_valid),
      .ByteReady(byte_ready4), .WrEn(wr_en4), .WrAddr(wr_addr4),
      .WrData(wr_data4), .Busy(busy4), .Done(done4)
   );

   // write monitor, 16-bit instance: every WrEn must match the next expected write
   always @(negedge clk) begin
      logic [31:0] exp;
      if (wr_en === 1'b1) begin
         checks++;
         if (q16.size() == 0) begin
            errors++;
            $display("FAIL wr16_unexpected: got addr=%h data=%h, expected no write", wr_addr, wr_data);
         end else begin
            exp = q16.pop_front();
            if ({wr_addr, wr_data} !== exp) begin
               errors++;
               $display("FAIL wr16_data: got addr=%h data=%h, expected addr=%h data=%h",
                        wr_addr, wr_data, exp[31:16], exp[15:0]);
            end
         end
      end
   end

   // write monitor, 4-bit instance
   always @(negedge clk) begin
      logic [31:0] exp;
      if (wr_en4 === 1'b1) begin
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL wr4_unexpected: got addr=%h data=%h, expected no write", wr_addr4, wr_data4);
         end else begin
            exp = q4.pop_front();
            if ({12'h000, wr_addr4, wr_data4} !== exp) begin
               errors++;
               $display("FAIL wr4_data: got addr=%h data=%h, expected addr=%h data=%h",
                        wr_addr4, wr_data4, exp[31:16], exp[15:0]);
            end
         end
      end
   end

   // Runs one load of the words in wq. sel=1 targets the 4-bit instance.
   // Expected writes are queued up front; the monitors pop them.
   task automatic load(input bit sel, input logic [15:0] base, input logic [15:0] cnt,
                       input int nwords, input bit toggle, input bit midstart, input bit abort_hi);
      logic [15:0] a;
      logic [15:0] exp_end;
      logic [7:0]  byt;
      bit          phase, rdy, accepted, ms_active;
      int          budget, w;
      if (!abort_hi) begin
         for (int i = 0; i < nwords; i++) begin
            a = base + 16'(i);
            if (sel) begin
               a = a & 16'h000F;
               q4.push_back({a, wq[i]});
            end else begin
               q16.push_back({a, wq[i]});
            end
         end
      end
      @(negedge clk);
      if (sel) begin
         base_addr4 = base[3:0]; word_count4 = cnt[3:0]; start4 = 1'b1;
      end else begin
         base_addr = base; word_count = cnt; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; start4 = 1'b0;
      phase = 1'b1; ms_active = 1'b0;
      for (int b = 0; b < 2 * nwords; b++) begin
         byt = b[0] ? wq[b / 2][7:0] : wq[b / 2][15:8];
         accepted = 1'b0; budget = 0;
         while (!accepted && budget < 20) begin
            byte_in = byt;
            byte_valid = toggle ? phase : 1'b1;
            phase = ~phase;
            rdy = sel ? byte_ready4 : byte_ready;
            @(posedge clk);
            accepted = rdy && byte_valid;
            @(negedge clk);
            if (ms_active) begin
               start = 1'b0; ms_active = 1'b0;
            end
            if (toggle && !byte_valid && rdy) begin
               checks++;
               if ((sel ? byte_ready4 : byte_ready) !== 1'b1) begin
                  errors++;
                  $display("FAIL stall_ready: got %b, expected 1", sel ? byte_ready4 : byte_ready);
               end
            end
            budget++;
         end
         if (!accepted) begin
            checks++; errors++;
            $display("FAIL byte_timeout: byte %0d not accepted within 20 cycles, expected acceptance", b);
            byte_valid = 1'b0;
            return;
         end
         if (b == 0 && abort_hi) begin
            byte_valid = 1'b0;
            return;
         end
         if (b == 0 && midstart) begin
            start = 1'b1; base_addr = 16'h5555; word_count = 16'd7; ms_active = 1'b1;
         end
      end
      byte_valid = 1'b0;
      w = 0;
      while ((sel ? done4 : done) !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if ((sel ? done4 : done) !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b, expected 1", sel ? done4 : done);
      end
      checks++;
      if ((sel ? busy4 : busy) !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_done: got %b, expected 0", sel ? busy4 : busy);
      end
      checks++;
      if ((sel ? q4.size() : q16.size()) != 0) begin
         errors++;
         $display("FAIL writes_missing: %0d writes outstanding, expected 0", sel ? q4.size() : q16.size());
      end
      exp_end = base + 16'(nwords);
      if (sel) exp_end = exp_end & 16'h000F;
      checks++;
      if ((sel ? {12'h000, wr_addr4} : wr_addr) !== exp_end) begin
         errors++;
         $display("FAIL end_addr: got %h, expected %h", sel ? {12'h000, wr_addr4} : wr_addr, exp_end);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({byte_ready, wr_en, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got rdy/wren/busy/done=%b, expected 0000", {byte_ready, wr_en, busy, done});
      end
      checks++;
      if (wr_addr !== 16'h0000) begin
         errors++;
         $display("FAIL reset_addr: got %h, expected 0000", wr_addr);
      end
      checks++;
      if (wr_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_data: got %h, expected 0000", wr_data);
      end
      checks++;
      if ({byte_ready4, wr_en4, busy4, done4, wr_addr4} !== 8'h00) begin
         errors++;
         $display("FAIL reset_dut4: got %h, expected 00", {byte_ready4, wr_en4, busy4, done4, wr_addr4});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      wq = '{16'h1234, 16'hABCD};
      load(1'b0, 16'h0010, 16'd2, 2, 1'b0, 1'b0, 1'b0);
      // bytes offered while in DONE must be ignored
      byte_in = 8'h77; byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      checks++;
      if (byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL done_ready: got %b, expected 0", byte_ready);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_held: got %b, expected 1", done);
      end
   endtask

   task automatic test_stall();
      wq = '{16'h1234, 16'hABCD};
      load(1'b0, 16'h0010, 16'd2, 2, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      wq = '{16'h5A0F, 16'hC3E1};
      load(1'b0, 16'hFFFF, 16'd2, 2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      wq = '{16'h9876};
      load(1'b0, 16'h0020, 16'd1, 1, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({byte_ready, wr_en, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL abort_flags: got rdy/wren/busy/done=%b, expected 0000", {byte_ready, wr_en, busy, done});
      end
      checks++;
      if ({wr_addr, wr_data} !== 32'h0) begin
         errors++;
         $display("FAIL abort_regs: got addr=%h data=%h, expected 0000/0000", wr_addr, wr_data);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      wq = '{16'h0F1E, 16'h2D3C, 16'h4B5A};
      load(1'b0, 16'h0100, 16'd3, 3, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_start_midload();
      wq = '{16'hDEAD, 16'hBEEF, 16'hCAFE};
      load(1'b0, 16'h0200, 16'd3, 3, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_wordcount0();
      wq.delete();
      for (int i = 0; i < 16; i++) wq.push_back(16'($urandom));
      load(1'b1, 16'h000A, 16'h0000, 16, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
      base_addr = '0; word_count = '0; base_addr4 = '0; word_count4 = '0;
      byte_in = '0; byte_valid = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_reset_mid();
      test_start_midload();
      test_wordcount0();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
